alu_mul_sequencer: RTL and testbench

- Multi-cycle 8x8 -> 16-bit shift-add multiplier built on the 8-bit ALU.
- This block is the initiator side of the ALU interface: it drives the op select and both operands, and consumes the result and flags.
- No multiplier hardware of its own; every add and shift is issued to the ALU, one operation per cycle.
- Sits beside the CPU control unit, which issues start and reads product when done pulses.

---
 rtl/alu_mul_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - 8x8 -> 16-bit shift-add multiplier sequenced over an external 8-bit ALU
//
// Purpose:
//   Computes {ACC,Q} = M * Q by issuing one ALU operation per cycle:
//   alternating ADD (ACC + (Q[0] ? M : 0)) and SHR (shift {C,ACC,Q} right).
//   The add is never skipped, so latency is fixed.
//   The block has no multiplier or adder of its own.
//
// Optional build macro:
//   MUL_SIGNED_EN - two's-complement signed multiply.
//                   C takes the true sign of each sum.
//                   The last partial product is subtracted.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          request, sampled only in IDLE
//   i_multiplicand   M, captured when start is accepted
//   i_multiplier     Q, captured when start is accepted
//   o_busy           high from the cycle after start is accepted through the done cycle
//   o_done           one-cycle pulse; o_product is valid from this cycle
//   o_product        {ACC,Q}, held until overwritten by the next result
//   o_alu_select     ALU op: 00 ADD, 01 SUB, 10 SHL, 11 SHR
//   o_alu_a          ALU operand A
//   o_alu_b          ALU operand B
//   i_alu_result     ALU result, combinational in the same cycle
//   i_alu_carry      ADD carry-out / SHR bit shifted out
//   i_alu_overflow   signed overflow of ADD/SUB (used only with MUL_SIGNED_EN)

module alu_mul_sequencer #(
    parameter int ITER = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_multiplicand,
    input  logic [7:0]  i_multiplier,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_product,
    output logic [1:0]  o_alu_select,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_carry,
    input  logic        i_alu_overflow
);

    localparam int             CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SHR = 2'b11;

    // S_LATCH loads the product register one cycle ahead of S_DONE.
    // As a result, done and a registered product appear together.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [7:0]     r_acc;
    logic [7:0]     r_q;
    logic [7:0]     r_m;
    logic           r_c;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_product;
    logic           w_c_next;

`ifdef MUL_SIGNED_EN
    // True sign of the 9-bit sum/difference.
    // This makes the following shift arithmetic.
    assign w_c_next = i_alu_result[7] ^ i_alu_overflow;
`else
    logic w_unused_overflow;
    assign w_unused_overflow = i_alu_overflow;
    assign w_c_next          = i_alu_carry;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_alu_select = ALU_ADD;
        o_alu_a      = 8'h00;
        o_alu_b      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_ADD;
                end
            end
            S_ADD: begin
                o_alu_a = r_acc;
                o_alu_b = r_q[0] ? r_m : 8'h00;
`ifdef MUL_SIGNED_EN
                // The multiplier's MSB has negative weight.
                if (r_count == LAST && r_q[0]) begin
                    o_alu_select = ALU_SUB;
                end
`endif
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                o_alu_select = ALU_SHR;
                o_alu_a      = r_acc;
                w_next_state = (r_count == LAST) ? S_LATCH : S_ADD;
            end
            S_LATCH: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= 8'h00;
            r_q       <= 8'h00;
            r_m       <= 8'h00;
            r_c       <= 1'b0;
            r_count   <= '0;
            r_product <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc   <= 8'h00;
                        r_q     <= i_multiplier;
                        r_m     <= i_multiplicand;
                        r_count <= '0;
                    end
                end
                S_ADD: begin
                    r_acc <= i_alu_result;
                    r_c   <= w_c_next;
                end
                S_SHIFT: begin
                    // The ALU fills the vacated MSB with 0.
                    // It is replaced by the saved carry/sign.
                    r_acc <= {r_c, i_alu_result[6:0]};
                    r_q   <= {i_alu_carry, r_q[7:1]};
                    if (r_count != LAST) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_LATCH: begin
                    r_product <= {r_acc, r_q};
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - self-checking bench for alu_mul_sequencer with a behavioural 8-bit ALU

module tb_alu_mul_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_multiplicand;
    logic [7:0]  i_multiplier;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_product;
    logic [1:0]  o_alu_select;
    logic [7:0]  o_alu_a;
    logic [7:0]  o_alu_b;
    logic [7:0]  i_alu_result;
    logic        i_alu_carry;
    logic        i_alu_overflow;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    alu_mul_sequencer dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_product      (o_product),
        .o_alu_select   (o_alu_select),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .i_alu_result   (i_alu_result),
        .i_alu_carry    (i_alu_carry),
        .i_alu_overflow (i_alu_overflow)
    );

    logic [8:0] alu_wide;
    always_comb begin
        alu_wide       = 9'h000;
        i_alu_result   = 8'h00;
        i_alu_carry    = 1'b0;
        i_alu_overflow = 1'b0;
        case (o_alu_select)
            2'b00: begin
                alu_wide       = {1'b0, o_alu_a} + {1'b0, o_alu_b};
                i_alu_result   = alu_wide[7:0];
                i_alu_carry    = alu_wide[8];
                i_alu_overflow = (o_alu_a[7] == o_alu_b[7]) && (alu_wide[7] != o_alu_a[7]);
            end
            2'b01: begin
                alu_wide       = {1'b0, o_alu_a} - {1'b0, o_alu_b};
                i_alu_result   = alu_wide[7:0];
                i_alu_carry    = alu_wide[8];
                i_alu_overflow = (o_alu_a[7] != o_alu_b[7]) && (alu_wide[7] != o_alu_a[7]);
            end
            2'b10: begin
                i_alu_result = {o_alu_a[6:0], 1'b0};
                i_alu_carry  = o_alu_a[7];
            end
            default: begin
                i_alu_result = {1'b0, o_alu_a[7:1]};
                i_alu_carry  = o_alu_a[0];
            end
        endcase
    end

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected op for ALU step i (0..15) with the multiplier q.
    function automatic logic [1:0] exp_sel(input int i, input logic [7:0] q);
        if (i % 2 == 1) return 2'b11;
`ifdef MUL_SIGNED_EN
        if (i == 14 && q[7]) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
        int cyc;
        int sel_bad;
        i_multiplicand = m;
        i_multiplier   = q;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        chk("busy_rise", {31'd0, o_busy}, 32'd1);
        chk("first_add_b", {24'd0, o_alu_b}, {24'd0, (q[0] ? m : 8'h00)});
        cyc     = 0;
        sel_bad = 0;
        while (!o_done && cyc < 40) begin
            if (cyc < 16 && o_alu_select !== exp_sel(cyc, q)) sel_bad++;
            tick();
            cyc++;
        end
        chk("done_latency", cyc, 17);
        chk("product", {16'd0, o_product}, {16'd0, exp});
        chk("alu_sel_seq", sel_bad, 0);
        tick();
        chk("done_pulse_end", {31'd0, o_done}, 32'd0);
        chk("busy_end", {31'd0, o_busy}, 32'd0);
        chk("product_hold", {16'd0, o_product}, {16'd0, exp});
    endtask

    initial begin
        int dones;
        int first_at;
        int second_at;
        int guard;
        logic [15:0] seen_product;

`ifdef MUL_SIGNED_EN
        vecs[0] = '{8'h0C, 8'h0A, 16'h0078};
        vecs[1] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{8'h05, 8'hFD, 16'hFFF1};
        vecs[4] = '{8'h00, 8'hB7, 16'h0000};
        vecs[5] = '{8'h03, 8'h05, 16'h000F};
`else
        vecs[0] = '{8'h0C, 8'h0A, 16'h0078};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hB7, 16'h0000};
        vecs[3] = '{8'h03, 8'h05, 16'h000F};
        vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[5] = '{8'h80, 8'h02, 16'h0100};
`endif

        i_rst_n        = 1'b0;
        i_start        = 1'b0;
        i_multiplicand = 8'h00;
        i_multiplier   = 8'h00;
        tick();
        tick();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_product", {16'd0, o_product}, 32'd0);
        chk("rst_sel", {30'd0, o_alu_select}, 32'd0);
        chk("rst_a", {24'd0, o_alu_a}, 32'd0);
        chk("rst_b", {24'd0, o_alu_b}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].m, vecs[v].q, vecs[v].exp);
        end

        // Start pulsed mid-operation with other operands must be ignored.
        i_multiplicand = 8'h0C;
        i_multiplier   = 8'h0A;
        i_start        = 1'b1;
        tick();
        i_start      = 1'b0;
        dones        = 0;
        seen_product = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            if (k == 5) begin
                i_start        = 1'b1;
                i_multiplicand = 8'h55;
                i_multiplier   = 8'h33;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                dones++;
                seen_product = o_product;
            end
            tick();
        end
        chk("ignored_start_dones", dones, 1);
        chk("ignored_start_product", {16'd0, seen_product}, 32'h0078);

        // Start held high restarts on each return to IDLE.
        i_multiplicand = 8'h0C;
        i_multiplier   = 8'h0A;
        i_start        = 1'b1;
        tick();
        first_at  = -1;
        second_at = -1;
        for (int k = 0; k < 45; k++) begin
            if (o_done) begin
                if (first_at < 0) first_at = k;
                else if (second_at < 0) second_at = k;
            end
            tick();
        end
        i_start = 1'b0;
        chk("held_start_first", first_at, 17);
        chk("held_start_second", second_at, 36);
        guard = 0;
        while (o_busy && guard < 40) begin
            tick();
            guard++;
        end
        chk("held_start_drain", {31'd0, o_busy}, 32'd0);

        // Reset mid-operation.
        i_multiplicand = 8'h77;
        i_multiplier   = 8'h99;
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_done", {31'd0, o_done}, 32'd0);
        chk("midrst_product", {16'd0, o_product}, 32'd0);
        chk("midrst_sel", {30'd0, o_alu_select}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        dones   = 0;
        guard   = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_done) dones++;
            if (o_busy) guard++;
            tick();
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_stays_idle", guard, 0);
        run_op(8'h03, 8'h05, 16'h000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
